// File: rtl/camera_fifo_sched_pkg.sv
// Shared types and helpers for the camera FIFO burst scheduler.
package camera_fifo_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ARB  = 3'd1;
  localparam state_t S_REQ  = 3'd2;
  localparam state_t S_DATA = 3'd3;
  localparam state_t S_DONE = 3'd4;

  // Fixed width of burst_ch; supports up to 8 channels.
  localparam int CH_W = 3;

  function automatic logic [15:0] min_len(input logic [15:0] level, input logic [15:0] blen);
    return (level < blen) ? level : blen;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational rotate-priority encoder: first set bit of elig at or after rr_ptr.
module rr_arbiter_n
  import camera_fifo_sched_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] elig,
  input  logic [CH_W-1:0] rr_ptr,
  output logic [CH_W-1:0] grant,
  output logic            any_grant
);

  localparam logic [CH_W:0] NCH = (CH_W+1)'(N_CH);

  logic [15:0]   elig_ext;
  logic [CH_W:0] idx;

  // Scan from the farthest offset down so the closest eligible channel wins last.
  always_comb begin
    elig_ext  = 16'(elig);
    grant     = '0;
    any_grant = |elig;
    idx       = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (idx >= NCH) idx = idx - NCH;
      if (elig_ext[idx]) grant = idx[CH_W-1:0];
    end
  end

endmodule

// File: rtl/camera_fifo_burst_sched.sv
// Round-robin burst scheduler sharing one DDR write-master port among N camera FIFOs.
module camera_fifo_burst_sched
  import camera_fifo_sched_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int LVL_W     = 11,
  parameter int BURST_LEN = 16,
  parameter int LEN_W     = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [N_CH*LVL_W-1:0]  ch_level,
  input  logic [N_CH-1:0]        ch_rd_vld,
  input  logic [N_CH*DATA_W-1:0] ch_rd_data,
  output logic [N_CH-1:0]        ch_rd_en,
  output logic                   burst_req,
  output logic [CH_W-1:0]        burst_ch,
  output logic [LEN_W-1:0]       burst_len,
  input  logic                   burst_ack,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy
);

  localparam int NX = 2 ** CH_W;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [LEN_W-1:0]  beat_cnt;
  logic [N_CH-1:0]   elig;
  logic [CH_W-1:0]   grant;
  logic              any_grant;
  logic              beat;
  logic [NX-1:0]     vld_ext;
  logic [NX-1:0]     en_ext;
  logic [LVL_W-1:0]  lvl_ext [NX];
  logic [DATA_W-1:0] dat_ext [NX];

  // Channel views padded to 2**CH_W so burst_ch/grant index them directly.
  always_comb begin
    for (int i = 0; i < NX; i++) begin
      lvl_ext[i] = '0;
      dat_ext[i] = '0;
    end
    elig = '0;
    for (int i = 0; i < N_CH; i++) begin
      lvl_ext[i] = ch_level[i*LVL_W +: LVL_W];
      dat_ext[i] = ch_rd_data[i*DATA_W +: DATA_W];
      elig[i]    = (lvl_ext[i] >= LVL_W'(BURST_LEN)) || (flush && (lvl_ext[i] != '0));
    end
  end

  rr_arbiter_n #(.N_CH(N_CH)) u_arb (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign vld_ext   = NX'(ch_rd_vld);
  assign m_valid   = (state == S_DATA) && vld_ext[burst_ch];
  assign m_data    = dat_ext[burst_ch];
  assign beat      = m_valid && m_ready;
  assign m_last    = m_valid && (beat_cnt == burst_len - LEN_W'(1));
  assign en_ext    = NX'(beat) << burst_ch;
  assign ch_rd_en  = en_ext[N_CH-1:0];
  assign burst_req = (state == S_REQ);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      burst_ch  <= '0;
      burst_len <= '0;
    end else begin
      case (state)
        S_IDLE: if (|elig) state <= S_ARB;
        S_ARB: begin
          if (any_grant) begin
            burst_ch  <= grant;
            burst_len <= LEN_W'(min_len(16'(lvl_ext[grant]), 16'(BURST_LEN)));
            state     <= S_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (burst_ack) begin
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (m_last) state <= S_DONE;
          end
        end
        S_DONE: begin
          rr_ptr <= (burst_ch == CH_W'(N_CH - 1)) ? '0 : burst_ch + CH_W'(1);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_onehot_pop: assert property (@(posedge clk) disable iff (rst) $onehot0(ch_rd_en));
  a_req_hold:   assert property (@(posedge clk) disable iff (rst) burst_req && !burst_ack |=> burst_req);
`endif

endmodule

// File: tb/tb_camera_fifo_burst_sched.sv
// Directed bench for camera_fifo_burst_sched with a simple FIFO data/pop model.
module tb_camera_fifo_burst_sched;

  localparam int N_CH      = 4;
  localparam int DATA_W    = 32;
  localparam int LVL_W     = 11;
  localparam int BURST_LEN = 16;
  localparam int LEN_W     = 9;

  logic                   clk = 1'b0;
  logic                   rst, flush, burst_ack, m_ready;
  logic [N_CH*LVL_W-1:0]  ch_level;
  logic [N_CH-1:0]        ch_rd_vld, ch_rd_en;
  logic [N_CH*DATA_W-1:0] ch_rd_data;
  logic                   burst_req, m_valid, m_last, busy;
  logic [2:0]             burst_ch;
  logic [LEN_W-1:0]       burst_len;
  logic [DATA_W-1:0]      m_data;

  logic [LVL_W-1:0] lvl  [N_CH] = '{default: '0};
  logic [N_CH-1:0]  vld_mask = '1;
  logic [23:0]      head [N_CH] = '{default: '0};
  int               pops [N_CH] = '{default: 0};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_level[i*LVL_W +: LVL_W]    = lvl[i];
    assign ch_rd_data[i*DATA_W +: DATA_W] = {8'(i), head[i]};
  end
  assign ch_rd_vld = vld_mask;

  // FIFO model: a pop advances that channel's data sequence.
  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (ch_rd_en[i]) begin
        head[i] <= head[i] + 24'd1;
        pops[i] <= pops[i] + 1;
      end
    end
  end

  camera_fifo_burst_sched #(
    .N_CH(N_CH), .DATA_W(DATA_W), .LVL_W(LVL_W), .BURST_LEN(BURST_LEN), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .ch_level(ch_level), .ch_rd_vld(ch_rd_vld),
    .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en), .burst_req(burst_req), .burst_ch(burst_ch),
    .burst_len(burst_len), .burst_ack(burst_ack), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; burst_ack = 1'b0; m_ready = 1'b0; vld_mask = '1;
    for (int i = 0; i < N_CH; i++) lvl[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for burst_req; cyc = negedges elapsed, or -1 on timeout.
  task automatic wait_req(input int budget, output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < budget) begin
      @(negedge clk); #1;
      cyc++;
      if (burst_req) found = 1'b1;
    end
    if (!found) cyc = -1;
  endtask

  // Holds ack low ack_wait cycles, acks, then streams with optional ready toggling and vld stall.
  task automatic run_burst(input int ack_wait, input bit ready_toggle, input int stall_lo,
                           input int stall_hi, input int abort_at,
                           output int gch, output int glen, output int beats, output int last_at,
                           output int data_err, output int pop_err, output int hold_err);
    logic [23:0]     h0;
    logic [31:0]     exp_d;
    logic [N_CH-1:0] exp_en;
    bit              xfer, done;
    int              c;
    gch = int'(burst_ch); glen = int'(burst_len);
    h0 = head[gch % N_CH];
    beats = 0; last_at = 0; data_err = 0; pop_err = 0; hold_err = 0;
    repeat (ack_wait) begin
      @(negedge clk); #1;
      if (!burst_req || int'(burst_ch) != gch || int'(burst_len) != glen || ch_rd_en !== '0)
        hold_err++;
    end
    @(negedge clk); burst_ack = 1'b1;
    c = 0; done = 1'b0;
    while (!done && c < 200) begin
      @(negedge clk);
      burst_ack = 1'b0;
      c++;
      m_ready  = ready_toggle ? (c % 2 == 1) : 1'b1;
      vld_mask = (c >= stall_lo && c <= stall_hi) ? '0 : '1;
      #1;
      xfer   = vld_mask[gch % N_CH] && m_ready;
      exp_en = xfer ? (N_CH'(1) << gch) : '0;
      if (m_valid !== vld_mask[gch % N_CH] || ch_rd_en !== exp_en) pop_err++;
      if (m_last && !m_valid) pop_err++;
      if (xfer) begin
        exp_d = {8'(gch), h0 + 24'(beats)};
        if (m_data !== exp_d) data_err++;
        beats++;
        if (m_last && last_at == 0) last_at = beats;
        if (m_last || beats == abort_at) done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (burst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", burst_req); end
    n_tests++; if (ch_rd_en !== '0) begin n_fail++; $display("FAIL reset_rd_en got %b exp 0", ch_rd_en); end
    n_tests++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid got %b/%b exp 0/0", m_valid, m_last); end
    n_tests++; if (burst_ch !== 3'd0 || burst_len !== '0) begin n_fail++; $display("FAIL reset_ch_len got %0d/%0d exp 0/0", burst_ch, burst_len); end
    n_tests++; if (dut.rr_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_rr_ptr got %0d exp 0", dut.rr_ptr); end
  endtask

  task automatic test_single();
    int cyc, gch, glen, beats, last_at, de, pe, he, p [N_CH];
    @(negedge clk);
    for (int i = 0; i < N_CH; i++) p[i] = pops[i];
    lvl[2] = 11'd16;
    wait_req(10, cyc);
    n_tests++; if (cyc != 2) begin n_fail++; $display("FAIL single_req_latency got %0d exp 2", cyc); end
    run_burst(0, 1'b0, 0, -1, 0, gch, glen, beats, last_at, de, pe, he);
    lvl[2] = '0;
    n_tests++; if (gch != 2 || glen != 16) begin n_fail++; $display("FAIL single_ch_len got %0d/%0d exp 2/16", gch, glen); end
    n_tests++; if (beats != 16 || last_at != 16) begin n_fail++; $display("FAIL single_beats got %0d last %0d exp 16/16", beats, last_at); end
    n_tests++; if (de != 0 || pe != 0) begin n_fail++; $display("FAIL single_stream got data_err %0d pop_err %0d exp 0/0", de, pe); end
    repeat (2) @(negedge clk); #1;
    n_tests++; if (pops[2] - p[2] != 16 || pops[0] != p[0] || pops[1] != p[1] || pops[3] != p[3])
      begin n_fail++; $display("FAIL single_pops got ch2 %0d exp 16 (others 0)", pops[2] - p[2]); end
    n_tests++; if (busy !== 1'b0 || dut.rr_ptr !== 3'd3) begin n_fail++; $display("FAIL single_rr_ptr got busy %b ptr %0d exp 0/3", busy, dut.rr_ptr); end
  endtask

  task automatic test_round_robin();
    int cyc, gch, glen, beats, last_at, de, pe, he;
    int exp_ch [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N_CH; i++) lvl[i] = 11'd20;
    for (int k = 0; k < 5; k++) begin
      wait_req(20, cyc);
      if (k > 0) begin
        n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL rr_gap burst %0d got %0d exp 4", k, cyc); end
      end
      run_burst(0, 1'b0, 0, -1, 0, gch, glen, beats, last_at, de, pe, he);
      n_tests++; if (gch != exp_ch[k] || glen != 16 || beats != 16)
        begin n_fail++; $display("FAIL rr_grant burst %0d got ch %0d len %0d beats %0d exp %0d/16/16", k, gch, glen, beats, exp_ch[k]); end
      n_tests++; if (de != 0 || pe != 0) begin n_fail++; $display("FAIL rr_stream burst %0d got %0d/%0d exp 0/0", k, de, pe); end
    end
    for (int i = 0; i < N_CH; i++) lvl[i] = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush_partial();
    int cyc, gch, glen, beats, last_at, de, pe, he, idle_err, p1;
    lvl[1] = 11'd5; idle_err = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (burst_req || busy) idle_err++;
    end
    n_tests++; if (idle_err != 0) begin n_fail++; $display("FAIL flush_no_req got %0d active cycles exp 0", idle_err); end
    p1 = pops[1];
    flush = 1'b1;
    wait_req(10, cyc);
    // Level and flush drop after ARB; the latched partial burst must still finish.
    flush = 1'b0; lvl[1] = '0;
    run_burst(0, 1'b0, 0, -1, 0, gch, glen, beats, last_at, de, pe, he);
    n_tests++; if (gch != 1 || glen != 5) begin n_fail++; $display("FAIL flush_ch_len got %0d/%0d exp 1/5", gch, glen); end
    n_tests++; if (beats != 5 || last_at != 5 || de != 0 || pe != 0)
      begin n_fail++; $display("FAIL flush_beats got %0d last %0d err %0d/%0d exp 5/5/0/0", beats, last_at, de, pe); end
    repeat (2) @(negedge clk);
    n_tests++; if (pops[1] - p1 != 5) begin n_fail++; $display("FAIL flush_pops got %0d exp 5", pops[1] - p1); end
    flush = 1'b1; idle_err = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (burst_req) idle_err++;
    end
    n_tests++; if (idle_err != 0) begin n_fail++; $display("FAIL flush_zero_level got %0d req cycles exp 0", idle_err); end
    flush = 1'b0;
  endtask

  task automatic test_stall();
    int cyc, gch, glen, beats, last_at, de, pe, he, p0;
    p0 = pops[0];
    lvl[0] = 11'd16;
    wait_req(10, cyc);
    run_burst(0, 1'b1, 3, 5, 0, gch, glen, beats, last_at, de, pe, he);
    lvl[0] = '0; m_ready = 1'b1; vld_mask = '1;
    n_tests++; if (gch != 0 || beats != 16 || last_at != 16) begin n_fail++; $display("FAIL stall_beats got ch %0d beats %0d last %0d exp 0/16/16", gch, beats, last_at); end
    n_tests++; if (de != 0 || pe != 0) begin n_fail++; $display("FAIL stall_stream got data_err %0d pop_err %0d exp 0/0", de, pe); end
    repeat (2) @(negedge clk);
    n_tests++; if (pops[0] - p0 != 16) begin n_fail++; $display("FAIL stall_pops got %0d exp 16", pops[0] - p0); end
  endtask

  task automatic test_reset_mid();
    int cyc, gch, glen, beats, last_at, de, pe, he, p2;
    p2 = pops[2];
    lvl[2] = 11'd16;
    wait_req(10, cyc);
    run_burst(0, 1'b0, 0, -1, 7, gch, glen, beats, last_at, de, pe, he);
    lvl[2] = '0;
    @(negedge clk); rst = 1'b1; m_ready = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (gch != 2 || beats != 7) begin n_fail++; $display("FAIL rstmid_beats got ch %0d beats %0d exp 2/7", gch, beats); end
    n_tests++; if (busy !== 1'b0 || burst_req !== 1'b0 || ch_rd_en !== '0)
      begin n_fail++; $display("FAIL rstmid_outputs got busy %b req %b rd_en %b exp 0/0/0", busy, burst_req, ch_rd_en); end
    n_tests++; if (dut.rr_ptr !== 3'd0) begin n_fail++; $display("FAIL rstmid_rr_ptr got %0d exp 0", dut.rr_ptr); end
    n_tests++; if (pops[2] - p2 != 7) begin n_fail++; $display("FAIL rstmid_pops got %0d exp 7", pops[2] - p2); end
    rst = 1'b0; m_ready = 1'b1;
  endtask

  task automatic test_ack_hold();
    int cyc, gch, glen, beats, last_at, de, pe, he, p3;
    p3 = pops[3];
    lvl[3] = 11'd16;
    wait_req(10, cyc);
    run_burst(10, 1'b0, 0, -1, 0, gch, glen, beats, last_at, de, pe, he);
    lvl[3] = '0;
    n_tests++; if (he != 0) begin n_fail++; $display("FAIL ackhold_stable got %0d bad cycles exp 0", he); end
    n_tests++; if (gch != 3 || glen != 16 || beats != 16 || de != 0 || pe != 0)
      begin n_fail++; $display("FAIL ackhold_burst got ch %0d len %0d beats %0d exp 3/16/16", gch, glen, beats); end
    repeat (2) @(negedge clk); #1;
    n_tests++; if (pops[3] - p3 != 16) begin n_fail++; $display("FAIL ackhold_pops got %0d exp 16", pops[3] - p3); end
    n_tests++; if (busy !== 1'b0 || dut.rr_ptr !== 3'd0) begin n_fail++; $display("FAIL ackhold_wrap got busy %b ptr %0d exp 0/0", busy, dut.rr_ptr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flush_partial();
    test_stall();
    test_reset_mid();
    test_ack_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
